// File: rtl/snd_pkg.sv
// Shared types and defaults for the sound command queue.
package snd_pkg;

  typedef enum logic [1:0] {
    NMI_IDLE    = 2'd0,
    NMI_PEND    = 2'd1,
    NMI_WAIT_RD = 2'd2
  } nmi_st_e;

  localparam int SND_CMD_W      = 8;
  localparam int SND_DEPTH_LOG2 = 2;

  // Smallest counter width that can hold period-1.
  function automatic int cnt_w_for(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// Register-array command FIFO; all state advances only when en_i is high.
// Also exposes the post-update head/count so the owner can register them.
module snd_cmd_fifo
  import snd_pkg::*;
#(
  parameter int W  = SND_CMD_W,
  parameter int AW = SND_DEPTH_LOG2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_nxt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  head_nxt_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees a slot in the same tick, so push is accepted when full+pop.
  assign wr_en   = push_i & (~full_o | pop_ok);
  assign rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
  assign cnt_d   = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop_ok);

  // New head is the incoming word when it lands exactly at the read pointer.
  assign head_nxt_o  = (wr_en && (rd_d == wr_q)) ? din_i : mem_q[rd_d];
  assign count_o     = cnt_q;
  assign count_nxt_o = cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && wr_en) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/snd_cmd_queue.sv
// Sound command queue: FIFO'd play requests, NMI handshake, periodic timer IRQ.
// Define SNDQ_STATUS_EN to drive cmd_count/overflow; otherwise both read 0.
module snd_cmd_queue
  import snd_pkg::*;
#(
  parameter int CMD_W      = SND_CMD_W,
  parameter int DEPTH_LOG2 = SND_DEPTH_LOG2,
  parameter int IRQ_PERIOD = 33333,
  parameter int CNT_W      = 17
) (
  input  logic                  clk40M,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [CMD_W-1:0]      sndno,
  input  logic                  sndstart,
  input  logic                  com_rd,
  output logic [CMD_W-1:0]      comlatch,
  output logic                  cpu_nmi,
  input  logic                  cpu_nmia,
  output logic                  cpu_irq,
  input  logic                  cpu_irqa,
  output logic [DEPTH_LOG2:0]   cmd_count,
  output logic                  overflow
);

  localparam bit                TMR_ON   = (IRQ_PERIOD > 0);
  localparam logic [CNT_W-1:0]  TMR_LAST = TMR_ON ? CNT_W'(IRQ_PERIOD - 1) : '0;

  logic                psndstart_q, pcom_rd_q;
  logic                push, pop;
  logic [DEPTH_LOG2:0] count, count_nxt;
  logic                full, empty;
  logic [CMD_W-1:0]    head_nxt, comlatch_q;
  nmi_st_e             nmi_q, nmi_d;
  logic [CNT_W-1:0]    tmr_q, tmr_d;
  logic                irq_q, irq_d, tmr_wrap;

  assign push = sndstart & ~psndstart_q;
  assign pop  = com_rd & ~pcom_rd_q & ~empty;

  snd_cmd_fifo #(.W(CMD_W), .AW(DEPTH_LOG2)) u_fifo (
    .clk_i       (clk40M),
    .rst_i       (reset),
    .en_i        (clk_en),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       (sndno),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .full_o      (full),
    .empty_o     (empty),
    .head_nxt_o  (head_nxt)
  );

  always_comb begin
    nmi_d = nmi_q;
    case (nmi_q)
      NMI_IDLE:    if (!empty) nmi_d = NMI_PEND;
      NMI_PEND:    if (pop) nmi_d = NMI_IDLE;
                   else if (cpu_nmia) nmi_d = NMI_WAIT_RD;
      NMI_WAIT_RD: if (pop) nmi_d = NMI_IDLE;
      default:     nmi_d = NMI_IDLE;
    endcase
  end

  assign tmr_wrap = TMR_ON && (tmr_q == TMR_LAST);
  assign tmr_d    = (!TMR_ON || tmr_wrap) ? '0 : tmr_q + CNT_W'(1);
  // Set beats a same-tick acknowledge.
  assign irq_d    = tmr_wrap ? 1'b1 : (cpu_irqa ? 1'b0 : irq_q);

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      psndstart_q <= 1'b0;
      pcom_rd_q   <= 1'b0;
      comlatch_q  <= '0;
      nmi_q       <= NMI_IDLE;
      tmr_q       <= '0;
      irq_q       <= 1'b0;
    end else if (clk_en) begin
      psndstart_q <= sndstart;
      pcom_rd_q   <= com_rd;
      if (count_nxt != '0) comlatch_q <= head_nxt;
      nmi_q       <= nmi_d;
      tmr_q       <= tmr_d;
      irq_q       <= irq_d;
    end
  end

  assign comlatch = comlatch_q;
  assign cpu_nmi  = (nmi_q == NMI_PEND);
  assign cpu_irq  = irq_q;

`ifdef SNDQ_STATUS_EN
  logic overflow_q;

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset)                        overflow_q <= 1'b0;
    else if (clk_en && push && full && !pop) overflow_q <= 1'b1;
  end

  assign cmd_count = count;
  assign overflow  = overflow_q;
`else
  logic unused_status;
  assign unused_status = &{1'b0, full, count};
  assign cmd_count     = '0;
  assign overflow      = 1'b0;
`endif

endmodule
